pcode_packer: RTL
=================

# pcode_packer

Downstream consumer of the P-code generator. Drives the generator's chip-advance enable, samples its serial chip output and packs chips MSB-first into WORD_WIDTH-bit words. Buffers the words in a small FIFO and presents them on a valid/ready stream to the code-encryption / export stage. Applies backpressure by withholding the generator enable when the FIFO is full, so no chip is ever lost or duplicated.

## Interface
Parameters:
- WORD_WIDTH, 32, bits per packed word; power of two, ≥ 8
- FIFO_DEPTH, 4, words of buffering; power of two, ≥ 2
- CNT_WIDTH, 16, width of the word-count request

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk externally
- start  in  1  capture request; accepted only in IDLE with num_words ≠ 0
- num_words  in  CNT_WIDTH  words to produce; latched on accepted start
- abort  in  1  synchronous cancel; takes priority over all other inputs
- chip_in  in  1  generator chip output (preg), combinational from the generator
- gen_en  out  1  chip-advance enable to generator
- word_data  out  WORD_WIDTH  FIFO head word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts head when word_valid & word_ready
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on completion

## Operation
- FSM states: IDLE, FILL, DRAIN.
- IDLE: start & num_words≠0 → FILL. Latch words_left=num_words; clear bit_cnt and shift register. start with num_words=0 is ignored. start outside IDLE is ignored.
- FILL: gen_en = (fifo_count < FIFO_DEPTH).
  - Each cycle with gen_en=1: sample chip_in, sreg ← {sreg[W-2:0], chip_in}, bit_cnt+1.
  - The first chip of a word lands in bit W-1.
  - When bit_cnt = W-1 and gen_en=1: push {sreg[W-2:0], chip_in} into the FIFO, bit_cnt ← 0, words_left−1.
  - When words_left = 1 and a push occurs → DRAIN.
- DRAIN: gen_en=0. When fifo_count=0 → IDLE with a done pulse in the same transition cycle (done high for the cycle in which state returns to IDLE).
- FIFO:
  - A pop occurs on word_valid & word_ready in any state.
  - Simultaneous push and pop leaves the count unchanged; when the FIFO was full, the pop frees the slot and the push succeeds.
  - gen_en depends only on the registered count, never on word_ready.
- abort (any state):
  - Next state IDLE.
  - FIFO flushed, partial word discarded, counters cleared.
  - No done pulse.
  - gen_en forced 0 in the abort cycle.
- Reset values: gen_en=0, word_valid=0, word_data=0, busy=0, done=0, state IDLE, fifo_count=0.
- Width rules:
  - bit_cnt is log2(WORD_WIDTH) bits and wraps naturally.
  - fifo_count is log2(FIFO_DEPTH)+1 bits.
  - words_left is CNT_WIDTH bits and never decrements below 1 in FILL.

## Timing
- start sampled in cycle 0.
- FILL from cycle 1: gen_en high in cycles 1..W if unstalled.
- First word_valid in cycle W+1 (33 for W=32).
- Sustained throughput: one word per W cycles with word_ready=1. gen_en never drops while the consumer keeps pace.
- FIFO full with ready=0: gen_en low from the cycle after the filling push. It resumes the cycle after the first pop.
- done: one cycle after the final pop (empty FIFO observed registered).
- word_data is registered FIFO head: valid in the same cycle as word_valid, stable while valid & !ready.

## Structure
- Package pcode_pkg: state enum {IDLE, FILL, DRAIN}, default WORD_WIDTH/FIFO_DEPTH constants, clog2 helper.
- One sub-module, pcode_word_fifo: synchronous FIFO with count, full/empty, async active-low reset.
- The top holds the FSM, the shift register and the counters.

## Test plan
- Basic: start, num_words=2, ready=1, chip_in from a reference generator model → word_valid at cycle 33 and 65. Each word equals 32 consecutive chips MSB-first. done at cycle 66. gen_en high for exactly 64 cycles.
- Backpressure: num_words=8, ready=0 until FIFO full → gen_en drops after the 4th push. Hold 100 cycles, then ready=1 → 8 words match the model with no skipped or repeated chip.
- Simultaneous push/pop at full: hold count=4, pulse ready in the push cycle → count stays 4, order preserved.
- Abort mid-word at bit 17 of word 3 → next cycle busy=0, word_valid=0, no done. A following start(1) yields a fresh word.
- Async reset in FILL: reset_n low mid-cycle → outputs zero immediately, state IDLE.
- start with num_words=0, and start while busy → ignored. State and outputs are unchanged.

Source files
------------

// File: rtl/pcode_pkg.sv
// Shared types and constants for the P-code chip packer.
package pcode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pcode_word_fifo.sv
// Word FIFO between the chip packer and the export stream; head is gated to
// zero while empty so the output bus never shows stale words.
module pcode_word_fifo
    import pcode_pkg::*;
#(
    parameter int W     = DEF_WORD_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/pcode_packer.sv
// Packs generator chips MSB-first into words, buffers them, and stalls the
// generator through gen_en whenever the word FIFO is full.
module pcode_packer
    import pcode_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_num_words,
    input  logic                  i_abort,
    input  logic                  i_chip_in,
    output logic                  o_gen_en,
    output logic [WORD_WIDTH-1:0] o_word_data,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BW = clog2(WORD_WIDTH);
    localparam int AW = clog2(FIFO_DEPTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] r_sreg;
    logic [BW-1:0]         r_bit_cnt;
    logic [CNT_WIDTH-1:0]  r_words_left;

    logic [WORD_WIDTH-1:0] w_word;
    logic [AW:0]           w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_gen_en;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_done;

    // gen_en looks only at registered FIFO state, never at word_ready.
    assign w_gen_en    = (r_state == FILL) & ~w_fifo_full & ~i_abort;
    assign w_push      = w_gen_en & (r_bit_cnt == BW'(WORD_WIDTH - 1));
    assign w_word      = {r_sreg[WORD_WIDTH-2:0], i_chip_in};
    assign w_pop       = o_word_valid & i_word_ready;
    assign w_accept    = (r_state == IDLE) & i_start & (i_num_words != '0) & ~i_abort;
    assign w_last_word = (r_words_left == CNT_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = FILL;
                FILL:    if (w_push && w_last_word) w_state_nxt = DRAIN;
                DRAIN: begin
                    if (w_fifo_count == '0) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_words_left <= '0;
        end else if (i_abort) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_words_left <= '0;
        end else if (w_accept) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_words_left <= i_num_words;
        end else if (w_gen_en) begin
            r_sreg    <= w_word;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            // The last word leaves words_left at 1; FILL never goes below it.
            if (w_push && !w_last_word) r_words_left <= r_words_left - 1'b1;
        end
    end

    pcode_word_fifo #(
        .W     (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_clr   (i_abort),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (o_word_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_gen_en     = w_gen_en;
    assign o_word_valid = ~w_fifo_empty;
    assign o_busy       = (r_state != IDLE);
    assign o_done       = w_done;

endmodule
